// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer issuing a single-cycle CPU clock-enable strobe; optional breakpoint via CPU_RUN_CTRL_BREAKPOINT_EN
module cpu_run_ctrl #(
    parameter int DIV_WIDTH = 16,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmdRun_i,
    input  logic                 cmdStop_i,
    input  logic                 cmdStep_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 haltFlag_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_WIDTH-1:0]  bpAddr_i,
    input  logic                 bpValid_i,
    output logic                 bpHit_o,
`endif
    output logic                 cpuEn_o,
    output logic [1:0]           state_o,
    output logic                 stepDone_o,
    output logic [CNT_WIDTH-1:0] cycleCount_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_e;
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 step_done_q, step_done_d;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                 fire;
    logic                 bp_stop;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic                 armed_q, armed_d;
    logic                 bp_hit_q, bp_hit_d;
    assign bp_stop = armed_q & bpValid_i & (pc_i == bpAddr_i) & fire;
    assign bpHit_o = bp_hit_q;
`else
    logic                 unused_pc;
    assign unused_pc = ^pc_i;
    assign bp_stop   = 1'b0;
`endif
    assign fire         = cnt_q >= divisor_i;
    assign cpuEn_o      = cpu_en_q;
    assign state_o      = state_q;
    assign stepDone_o   = step_done_q;
    assign cycleCount_o = cycle_count_q;
    // Next state: halt beats every command, stop beats step beats run; strobe only where a CPU cycle is granted
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_en_d    = 1'b0;
        step_done_d = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        armed_d     = armed_q;
        bp_hit_d    = bp_hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (haltFlag_i) begin
                    state_d = HALTED;
                end else if (!cmdStop_i && cmdStep_i) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end else if (!cmdStop_i && cmdRun_i) begin
                    state_d  = RUN;
                    cnt_d    = '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    armed_d  = 1'b0;
                    bp_hit_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (haltFlag_i) begin
                    state_d = HALTED;
                end else if (cmdStop_i) begin
                    state_d = IDLE;
                end else if (bp_stop) begin
                    state_d = IDLE;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b1;
`endif
                end else begin
                    cpu_en_d = fire;
                    cnt_d    = fire ? '0 : cnt_q + DIV_WIDTH'(1);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    armed_d  = armed_q | fire;
`endif
                end
            end
            STEP: begin
                state_d     = haltFlag_i ? HALTED : IDLE;
                step_done_d = !haltFlag_i;
            end
            default: ;
        endcase
        cycle_count_d = cpu_en_d ? cycle_count_q + CNT_WIDTH'(1) : cycle_count_q;
    end
    // Registered state and outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cpu_en_q      <= 1'b0;
            step_done_q   <= 1'b0;
            cycle_count_q <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            armed_q       <= 1'b0;
            bp_hit_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_en_q      <= cpu_en_d;
            step_done_q   <= step_done_d;
            cycle_count_q <= cycle_count_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            armed_q       <= armed_d;
            bp_hit_q      <= bp_hit_d;
`endif
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl; breakpoint checks need CPU_RUN_CTRL_BREAKPOINT_EN
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_run = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0, halt = 1'b0;
    logic [15:0] divisor = '0;
    logic [15:0] pc = '0;
    logic        cpu_en, step_done;
    logic [1:0]  state;
    logic [31:0] cycle_count;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic [15:0] bp_addr = 16'h0005;
    logic        bp_valid = 1'b0;
    logic        bp_hit;
`endif
    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;
    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    logic [31:0] exp_cnt = '0;
    int          n_tests = 0, n_fail = 0;

    cpu_run_ctrl dut (
        .clk(clk), .rst(rst),
        .cmdRun_i(cmd_run), .cmdStop_i(cmd_stop), .cmdStep_i(cmd_step),
        .divisor_i(divisor), .haltFlag_i(halt), .pc_i(pc),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .bpAddr_i(bp_addr), .bpValid_i(bp_valid), .bpHit_o(bp_hit),
`endif
        .cpuEn_o(cpu_en), .state_o(state), .stepDone_o(step_done), .cycleCount_o(cycle_count)
    );

    always #5 clk = ~clk;

    // Edge index: after edge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // CPU model: program counter advances once per granted enable
    always @(negedge clk) begin
        if (rst) pc <= '0;
        else if (cpu_en) pc <= pc + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void expect_pulse(input int c);
        exp_cnt = exp_cnt + 32'd1;
        q.push_back('{c, exp_cnt});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(input logic r, input logic s, input logic t);
        cmd_run = r; cmd_stop = s; cmd_step = t;
        @(negedge clk);
        cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_cnt = '0;
        q.delete();
    endtask

    // Scoreboard: every observed strobe must match the next expected edge and count
    always @(negedge clk) begin
        if (cpu_en) begin
            if (q.size() == 0) begin
                check("pulse_extra", 64'(cyc), 64'(0));
            end else begin
                mon_e = q.pop_front();
                check("pulse_edge", 64'(cyc), 64'(mon_e.cyc));
                check("pulse_count", 64'(cycle_count), 64'(mon_e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        tick(2);
        check("rst_state", 64'(state), 64'(0));
        check("rst_cpu_en", 64'(cpu_en), 64'(0));
        check("rst_step_done", 64'(step_done), 64'(0));
        check("rst_count", 64'(cycle_count), 64'(0));
        rst = 1'b0;
        // Run at full rate, then stop
        divisor = 16'd0;
        e = cyc + 1;
        for (int i = 1; i <= 10; i++) expect_pulse(e + i);
        cmd(1'b1, 1'b0, 1'b0);
        check("run_state", 64'(state), 64'(1));
        tick(10);
        check("run0_count", 64'(cycle_count), 64'(10));
        cmd(1'b0, 1'b1, 1'b0);
        check("stop_state", 64'(state), 64'(0));
        check("stop_cpu_en", 64'(cpu_en), 64'(0));
        tick(3);
        check("drain_run0", 64'(q.size()), 64'(0));
        // Divide by 4, then drop divisor to 0 while cnt==2
        divisor = 16'd3;
        e = cyc + 1;
        expect_pulse(e + 4);
        expect_pulse(e + 8);
        cmd(1'b1, 1'b0, 1'b0);
        tick(10);
        divisor = 16'd0;
        for (int i = 11; i <= 14; i++) expect_pulse(e + i);
        tick(4);
        cmd(1'b0, 1'b1, 1'b0);
        tick(2);
        check("drain_div", 64'(q.size()), 64'(0));
        // Single step, step+run, stop+run
        e = cyc + 1;
        expect_pulse(e);
        cmd(1'b0, 1'b0, 1'b1);
        check("step_state", 64'(state), 64'(2));
        check("step_done_early", 64'(step_done), 64'(0));
        tick(1);
        check("step_done", 64'(step_done), 64'(1));
        check("step_back_idle", 64'(state), 64'(0));
        check("step_cpu_en_off", 64'(cpu_en), 64'(0));
        tick(1);
        check("step_done_pulse", 64'(step_done), 64'(0));
        e = cyc + 1;
        expect_pulse(e);
        cmd(1'b1, 1'b0, 1'b1);
        check("step_run_state", 64'(state), 64'(2));
        tick(1);
        check("step_run_done", 64'(step_done), 64'(1));
        tick(1);
        cmd(1'b1, 1'b1, 1'b0);
        check("stop_run_state", 64'(state), 64'(0));
        tick(3);
        check("stop_run_idle", 64'(state), 64'(0));
        check("step_count", 64'(cycle_count), 64'(exp_cnt));
        check("drain_step", 64'(q.size()), 64'(0));
        // Reset in the middle of a step
        e = cyc + 1;
        expect_pulse(e);
        cmd(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rst_step_cpu_en", 64'(cpu_en), 64'(0));
        check("rst_step_done", 64'(step_done), 64'(0));
        check("rst_step_state", 64'(state), 64'(0));
        check("rst_step_count", 64'(cycle_count), 64'(0));
        rst = 1'b0;
        exp_cnt = '0;
        check("drain_rst_step", 64'(q.size()), 64'(0));
        // Halt during run
        divisor = 16'd1;
        e = cyc + 1;
        expect_pulse(e + 2);
        expect_pulse(e + 4);
        cmd(1'b1, 1'b0, 1'b0);
        tick(5);
        halt = 1'b1;
        tick(1);
        check("halt_state", 64'(state), 64'(3));
        check("halt_cpu_en", 64'(cpu_en), 64'(0));
        halt = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        tick(3);
        check("halt_sticky", 64'(state), 64'(3));
        check("halt_count", 64'(cycle_count), 64'(2));
        check("drain_halt", 64'(q.size()), 64'(0));
        do_reset();
        check("halt_rst_state", 64'(state), 64'(0));
        check("halt_rst_count", 64'(cycle_count), 64'(0));
        // Cycle counter wrap
        divisor = 16'd3;
        e = cyc + 1;
        expect_pulse(e + 4);
        cmd(1'b1, 1'b0, 1'b0);
        tick(5);
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count_q;
        check("wrap_preload", 64'(cycle_count), 64'(32'hFFFF_FFFF));
        exp_cnt = 32'hFFFF_FFFF;
        expect_pulse(e + 8);
        expect_pulse(e + 12);
        tick(7);
        cmd(1'b0, 1'b1, 1'b0);
        tick(2);
        check("drain_wrap", 64'(q.size()), 64'(0));
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        // Breakpoint at pc 5, then resume past it
        do_reset();
        divisor = 16'd0;
        bp_addr = 16'h0005;
        bp_valid = 1'b1;
        e = cyc + 1;
        for (int i = 1; i <= 5; i++) expect_pulse(e + i);
        cmd(1'b1, 1'b0, 1'b0);
        tick(6);
        check("bp_state", 64'(state), 64'(0));
        check("bp_hit", 64'(bp_hit), 64'(1));
        check("bp_pc", 64'(pc), 64'(5));
        tick(2);
        check("bp_cpu_en", 64'(cpu_en), 64'(0));
        check("drain_bp", 64'(q.size()), 64'(0));
        e = cyc + 1;
        for (int i = 1; i <= 4; i++) expect_pulse(e + i);
        cmd(1'b1, 1'b0, 1'b0);
        check("bp_hit_clear", 64'(bp_hit), 64'(0));
        tick(4);
        cmd(1'b0, 1'b1, 1'b0);
        check("bp_resume_pc", 64'(pc), 64'(9));
        check("bp_resume_state", 64'(state), 64'(0));
        tick(2);
        check("drain_bp_resume", 64'(q.size()), 64'(0));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
